// File: rtl/fpu_minmax_reduce_pkg.sv
// Shared FPU definitions for the min/max reduction controller:
// canonical NaN, exponent all-ones, FSM state encoding and the
// binary32 classification helper.
package fpu_minmax_reduce_pkg;

  localparam logic [31:0] CANON_NAN = 32'h7FC00000;
  localparam logic [7:0]  EXP_ONES  = 8'hFF;

  // DRAIN only exists when the operand path is pipelined.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd3
`ifdef FPU_MINMAX_REDUCE_PIPE_EN
    ,
    ST_DRAIN = 2'd2
`endif
  } state_e;

  // Classification of one binary32 value. mag = {exp, sig} orders
  // magnitudes monotonically because the hidden bit tracks exp != 0.
  typedef struct packed {
    logic        sign;
    logic        nan;
    logic        inf;
    logic        snan;
    logic [31:0] mag;
  } fp_cls_t;

  function automatic fp_cls_t fp_classify(input logic [31:0] d);
    fp_cls_t     c;
    logic [7:0]  e;
    logic [22:0] f;
    logic [23:0] sig;
    e      = d[30:23];
    f      = d[22:0];
    sig    = {(e != 8'h00), f};
    c.sign = d[31];
    c.nan  = (e == EXP_ONES) && (f != 23'd0);
    c.inf  = (e == EXP_ONES) && (f == 23'd0);
    c.snan = c.nan && !f[22];
    c.mag  = {e, sig};
    return c;
  endfunction

endpackage

// File: rtl/fpu_minmax_reduce_min_max.sv
// fpu_min_max: IEEE-754 minNum/maxNum on binary32 with pre-classified
// inputs. Two NaNs give the canonical NaN, one NaN yields the other
// operand, -0 orders below +0. nv_o flags any signaling NaN input.
module fpu_min_max
  import fpu_minmax_reduce_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  fp_cls_t     a_cls_i,
  input  fp_cls_t     b_cls_i,
  input  logic        op_max_i,
  output logic [31:0] res_o,
  output logic        nv_o
);

  logic a_lt_b;

  // Ordered compare of A against B on sign/magnitude.
  always_comb begin
    a_lt_b = 1'b0;
    if (a_cls_i.inf && b_cls_i.inf) begin
      a_lt_b = a_cls_i.sign && !b_cls_i.sign;
    end else if (a_cls_i.sign != b_cls_i.sign) begin
      a_lt_b = a_cls_i.sign;
    end else if (a_cls_i.sign) begin
      a_lt_b = a_cls_i.mag > b_cls_i.mag;
    end else begin
      a_lt_b = a_cls_i.mag < b_cls_i.mag;
    end
  end

  // NaN handling first, then pick by the ordered compare.
  always_comb begin
    res_o = a_i;
    if (a_cls_i.nan && b_cls_i.nan) begin
      res_o = CANON_NAN;
    end else if (a_cls_i.nan) begin
      res_o = b_i;
    end else if (b_cls_i.nan) begin
      res_o = a_i;
    end else if (op_max_i) begin
      res_o = a_lt_b ? b_i : a_i;
    end else begin
      res_o = a_lt_b ? a_i : b_i;
    end
  end

  assign nv_o = a_cls_i.snan || b_cls_i.snan;

endmodule

// File: rtl/fpu_minmax_reduce.sv
// fpu_minmax_reduce: sequences an FMIN/FMAX reduction over a stream of
// binary32 operands through one shared fpu_min_max instance.
// Optional macro FPU_MINMAX_REDUCE_PIPE_EN registers the operand and
// its classification ahead of fpu_min_max, keeps the accumulator's
// classification in a register and adds a DRAIN state (+1 latency).
module fpu_minmax_reduce
  import fpu_minmax_reduce_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             op_max_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [31:0]      op_data_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_data_o,
  output logic             res_invalid_o,
  output logic             busy_o
);

  state_e           state_q;
  logic             op_ready_q;
  logic             res_valid_q;
  logic             busy_q;
  logic             inv_q;
  logic [31:0]      acc_q;
  logic [CNT_W-1:0] rem_q;
  logic             first_q;
  logic             op_max_q;

  logic             hs;
  fp_cls_t          x_cls;
  logic [31:0]      mm_a;
  logic [31:0]      mm_b;
  fp_cls_t          mm_a_cls;
  fp_cls_t          mm_b_cls;
  logic [31:0]      mm_res;
  logic             mm_nv;
  logic             upd;

  assign hs    = op_ready_q && op_valid_i;
  assign x_cls = fp_classify(op_data_i);

`ifdef FPU_MINMAX_REDUCE_PIPE_EN
  logic [31:0] x_p0;
  fp_cls_t     x_cls_p0;
  logic        first_p0;
  logic        vld_p0;
  fp_cls_t     acc_cls_q;

  // Stage 0 -> 1: register the accepted operand and its flags.
  always_ff @(posedge clk_i) begin
    x_p0     <= op_data_i;
    x_cls_p0 <= x_cls;
    first_p0 <= first_q;
    if (reset_i) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= hs;
    end
  end

  // Keep the accumulator's classification alongside its value.
  always_ff @(posedge clk_i) begin
    if (vld_p0) begin
      acc_cls_q <= fp_classify(mm_res);
    end
  end

  assign mm_a     = first_p0 ? x_p0 : acc_q;
  assign mm_a_cls = first_p0 ? x_cls_p0 : acc_cls_q;
  assign mm_b     = x_p0;
  assign mm_b_cls = x_cls_p0;
  assign upd      = vld_p0;
`else
  fp_cls_t acc_cls;

  assign acc_cls  = fp_classify(acc_q);
  assign mm_a     = first_q ? op_data_i : acc_q;
  assign mm_a_cls = first_q ? x_cls : acc_cls;
  assign mm_b     = op_data_i;
  assign mm_b_cls = x_cls;
  assign upd      = hs;
`endif

  fpu_min_max u_min_max (
    .a_i      (mm_a),
    .b_i      (mm_b),
    .a_cls_i  (mm_a_cls),
    .b_cls_i  (mm_b_cls),
    .op_max_i (op_max_q),
    .res_o    (mm_res),
    .nv_o     (mm_nv)
  );

  // Job FSM with registered handshake outputs and accumulator fold.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      inv_q       <= 1'b0;
      acc_q       <= 32'h0;
      rem_q       <= '0;
      first_q     <= 1'b0;
      op_max_q    <= 1'b0;
    end else begin
      if (upd) begin
        acc_q <= mm_res;
        inv_q <= inv_q | mm_nv;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            op_max_q <= op_max_i;
            busy_q   <= 1'b1;
            inv_q    <= 1'b0;
            if (len_i != '0) begin
              rem_q      <= len_i;
              first_q    <= 1'b1;
              op_ready_q <= 1'b1;
              state_q    <= ST_ACCUM;
            end else begin
              acc_q       <= CANON_NAN;
              res_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_ACCUM: begin
          if (hs) begin
            first_q <= 1'b0;
            rem_q   <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              op_ready_q <= 1'b0;
`ifdef FPU_MINMAX_REDUCE_PIPE_EN
              state_q    <= ST_DRAIN;
`else
              res_valid_q <= 1'b1;
              state_q     <= ST_DONE;
`endif
            end
          end
        end
`ifdef FPU_MINMAX_REDUCE_PIPE_EN
        ST_DRAIN: begin
          res_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
`endif
        ST_DONE: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign op_ready_o    = op_ready_q;
  assign res_valid_o   = res_valid_q;
  assign res_data_o    = acc_q;
  assign res_invalid_o = inv_q;
  assign busy_o        = busy_q;

endmodule
